// File: rtl/bscan_pkg.sv
// Shared TAP state encoding and instruction opcodes for the boundary-scan chip.
package bscan_pkg;

  localparam int IR_W = 3;

  typedef enum logic [3:0] {
    S_TLR    = 4'h0,
    S_RTI    = 4'h1,
    S_SEL_DR = 4'h2,
    S_CAP_DR = 4'h3,
    S_SH_DR  = 4'h4,
    S_EX1_DR = 4'h5,
    S_PAU_DR = 4'h6,
    S_EX2_DR = 4'h7,
    S_UPD_DR = 4'h8,
    S_SEL_IR = 4'h9,
    S_CAP_IR = 4'hA,
    S_SH_IR  = 4'hB,
    S_EX1_IR = 4'hC,
    S_PAU_IR = 4'hD,
    S_EX2_IR = 4'hE,
    S_UPD_IR = 4'hF
  } tap_state_e;

  localparam logic [IR_W-1:0] OP_EXTEST  = 3'b000;
  localparam logic [IR_W-1:0] OP_SAMPLE  = 3'b001;
  localparam logic [IR_W-1:0] OP_INTEST  = 3'b010;
  localparam logic [IR_W-1:0] OP_IDCODE  = 3'b011;
  localparam logic [IR_W-1:0] OP_BYPASS  = 3'b111;
  localparam logic [IR_W-1:0] IR_CAPTURE = 3'b001;

endpackage

// File: rtl/bscan_chip_tap_fsm.sv
// 16-state TAP controller; the phase strobes are plain decodes of the current state.
module tap_fsm
  import bscan_pkg::*;
(
  input  logic       tck,
  input  logic       rst,
  input  logic       tms,
  output tap_state_e state,
  output logic       shift_dr,
  output logic       capture_dr,
  output logic       update_dr,
  output logic       shift_ir,
  output logic       capture_ir,
  output logic       update_ir
);

  tap_state_e state_r;
  tap_state_e next_s;

  // TMS arcs
  always_comb begin
    next_s = S_TLR;
    case (state_r)
      S_TLR:    next_s = tms ? S_TLR    : S_RTI;
      S_RTI:    next_s = tms ? S_SEL_DR : S_RTI;
      S_SEL_DR: next_s = tms ? S_SEL_IR : S_CAP_DR;
      S_CAP_DR: next_s = tms ? S_EX1_DR : S_SH_DR;
      S_SH_DR:  next_s = tms ? S_EX1_DR : S_SH_DR;
      S_EX1_DR: next_s = tms ? S_UPD_DR : S_PAU_DR;
      S_PAU_DR: next_s = tms ? S_EX2_DR : S_PAU_DR;
      S_EX2_DR: next_s = tms ? S_UPD_DR : S_SH_DR;
      S_UPD_DR: next_s = tms ? S_SEL_DR : S_RTI;
      S_SEL_IR: next_s = tms ? S_TLR    : S_CAP_IR;
      S_CAP_IR: next_s = tms ? S_EX1_IR : S_SH_IR;
      S_SH_IR:  next_s = tms ? S_EX1_IR : S_SH_IR;
      S_EX1_IR: next_s = tms ? S_UPD_IR : S_PAU_IR;
      S_PAU_IR: next_s = tms ? S_EX2_IR : S_PAU_IR;
      S_EX2_IR: next_s = tms ? S_UPD_IR : S_SH_IR;
      S_UPD_IR: next_s = tms ? S_SEL_DR : S_RTI;
      default:  next_s = S_TLR;
    endcase
  end

  always_ff @(posedge tck) begin
    if (rst) state_r <= S_TLR;
    else     state_r <= next_s;
  end

  assign state      = state_r;
  assign shift_dr   = (state_r == S_SH_DR);
  assign capture_dr = (state_r == S_CAP_DR);
  assign update_dr  = (state_r == S_UPD_DR);
  assign shift_ir   = (state_r == S_SH_IR);
  assign capture_ir = (state_r == S_CAP_IR);
  assign update_ir  = (state_r == S_UPD_IR);

endmodule

// File: rtl/bscan_chip.sv
// Boundary-scan chip: priority-encoder core wrapped by a BSR, IR, bypass and IDCODE.
// BSR bit 0 sits next to tdo; input cells fill the top IN_W bits in reverse pin order.
module bscan_chip
  import bscan_pkg::*;
#(
  parameter int          IN_W   = 4,
  parameter logic [31:0] IDCODE = 32'h0000_0001,
  localparam int         OUT_W  = $clog2(IN_W)
) (
  input  logic             tck,
  input  logic             rst,
  input  logic             tms,
  input  logic             tdi,
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] out,
  output logic             tdo,
  output logic             tdo_en
);

  localparam int L = IN_W + OUT_W;

  tap_state_e       state_s;
  logic             shift_dr_s, capture_dr_s, update_dr_s;
  logic             shift_ir_s, capture_ir_s, update_ir_s;
  logic             ir_reset_s, sel_bsr_s, sel_id_s;
  logic [IR_W-1:0]  ir_sr_r, instr_r;
  logic             bypass_r;
  logic [31:0]      idcode_r;
  logic [L-1:0]     bsr_r, upd_r, cap_vec_s;
  logic [IN_W-1:0]  upd_in_s, core_in_s;
  logic [OUT_W-1:0] core_s;

  tap_fsm u_tap (
    .tck        (tck),
    .rst        (rst),
    .tms        (tms),
    .state      (state_s),
    .shift_dr   (shift_dr_s),
    .capture_dr (capture_dr_s),
    .update_dr  (update_dr_s),
    .shift_ir   (shift_ir_s),
    .capture_ir (capture_ir_s),
    .update_ir  (update_ir_s)
  );

  // Instruction goes to BYPASS on the edge that enters Test-Logic-Reset
  assign ir_reset_s = (state_s == S_TLR) || ((state_s == S_SEL_IR) && tms);

  always_comb begin
    sel_bsr_s = 1'b0;
    sel_id_s  = 1'b0;
    case (instr_r)
      OP_EXTEST, OP_SAMPLE, OP_INTEST: sel_bsr_s = 1'b1;
      OP_IDCODE:                       sel_id_s  = 1'b1;
      default: begin
        sel_bsr_s = 1'b0;
        sel_id_s  = 1'b0;
      end
    endcase
  end

  always_comb begin
    for (int i = 0; i < IN_W; i++) upd_in_s[i] = upd_r[L-1-i];
    if (instr_r == OP_INTEST) core_in_s = upd_in_s;
    else                      core_in_s = in;
    core_s = {OUT_W{1'b0}};
    for (int i = 0; i < IN_W; i++) core_s = core_in_s[i] ? OUT_W'(i) : core_s;
  end

  always_comb begin
    cap_vec_s = {L{1'b0}};
    for (int i = 0; i < IN_W; i++) cap_vec_s[L-1-i] = in[i];
    cap_vec_s[OUT_W-1:0] = core_s;
  end

  always_comb begin
    if ((instr_r == OP_EXTEST) || (instr_r == OP_INTEST)) out = upd_r[OUT_W-1:0];
    else                                                  out = core_s;
  end

  always_ff @(posedge tck) begin
    if (rst) begin
      ir_sr_r <= 3'b000;
      instr_r <= OP_BYPASS;
    end else begin
      if (capture_ir_s)    ir_sr_r <= IR_CAPTURE;
      else if (shift_ir_s) ir_sr_r <= {tdi, ir_sr_r[IR_W-1:1]};
      else                 ir_sr_r <= ir_sr_r;
      if (ir_reset_s)       instr_r <= OP_BYPASS;
      else if (update_ir_s) instr_r <= ir_sr_r;
      else                  instr_r <= instr_r;
    end
  end

  // Data registers: shift wins over capture, only the selected register moves
  always_ff @(posedge tck) begin
    if (rst) begin
      bsr_r    <= {L{1'b0}};
      bypass_r <= 1'b0;
      idcode_r <= 32'h0000_0000;
    end else if (shift_dr_s) begin
      if (sel_bsr_s)     bsr_r    <= {tdi, bsr_r[L-1:1]};
      else if (sel_id_s) idcode_r <= {tdi, idcode_r[31:1]};
      else               bypass_r <= tdi;
    end else if (capture_dr_s) begin
      if (sel_bsr_s)     bsr_r    <= cap_vec_s;
      else if (sel_id_s) idcode_r <= IDCODE;
      else               bypass_r <= 1'b0;
    end
  end

  always_ff @(posedge tck) begin
    if (rst)                           upd_r <= {L{1'b0}};
    else if (update_dr_s && sel_bsr_s) upd_r <= bsr_r;
  end

  always_comb begin
    tdo = 1'b0;
    if (shift_ir_s) tdo = ir_sr_r[0];
    else if (shift_dr_s) begin
      if (sel_bsr_s)     tdo = bsr_r[0];
      else if (sel_id_s) tdo = idcode_r[0];
      else               tdo = bypass_r;
    end else tdo = 1'b0;
  end

  assign tdo_en = shift_dr_s | shift_ir_s;

endmodule
